vmx_pe_feeder: RTL and testbench

// - Transmit-side driver for the vmx_pe_16_8 systolic chain. It produces the per-cycle
//   {simd_mode, is_weight, data, sum_in} stream that enters PE0 of an NUM_PE-deep chain.
// - Accepts commands plus a valid/ready word stream. Tags weight words so that PE k

---
 rtl/vmx_pe_feeder.sv | 164 ++++++++++++++++
 tb/tb_vmx_pe_feeder.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vmx_pe_feeder.sv
// Transmit-side feeder for the vmx_pe_16_8 systolic chain: tags weight words per PE, streams vector words, then flushes the chain.
// Optional build macro VMX_FEED_BIAS_EN adds bias_in, which is applied as pe_sum_in on vector words.
module vmx_pe_feeder #(
    parameter int VECTOR_BITLEN  = 16,
    parameter int PRODUCT_BITLEN = 32,
    parameter int NUM_PE         = 8
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      cmd_valid,
    output logic                      cmd_ready,
    input  logic                      cmd_op,
    input  logic                      cmd_simd,
    input  logic [7:0]                cmd_len,
`ifdef VMX_FEED_BIAS_EN
    input  logic [PRODUCT_BITLEN-1:0] bias_in,
`endif
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [VECTOR_BITLEN-1:0]  s_data,
    output logic                      pe_simd_mode,
    output logic [7:0]                pe_is_weight,
    output logic [VECTOR_BITLEN-1:0]  pe_data,
    output logic [PRODUCT_BITLEN-1:0] pe_sum_in,
    output logic                      pe_valid,
    output logic                      busy,
    output logic                      done
);

    localparam logic [6:0] LAST_PE = 7'(NUM_PE - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_LOAD_W, ST_STREAM, ST_FLUSH} state_t;

    state_t                      state_reg, state_next;
    logic [6:0]                  idx_reg, idx_next;
    logic [7:0]                  cnt_reg, cnt_next;
    logic [6:0]                  fcnt_reg, fcnt_next;
    logic                        simd_reg, simd_next;
    logic [PRODUCT_BITLEN-1:0]   bias_reg, bias_next;

    logic [7:0]                  isw_next;
    logic [VECTOR_BITLEN-1:0]    data_next;
    logic [PRODUCT_BITLEN-1:0]   sum_next;
    logic                        valid_next;
    logic                        done_next;

    logic                        simd_mode_reg;
    logic [7:0]                  isw_reg;
    logic [VECTOR_BITLEN-1:0]    data_reg;
    logic [PRODUCT_BITLEN-1:0]   sum_reg;
    logic                        valid_reg;
    logic                        done_reg;

    assign cmd_ready = (state_reg == ST_IDLE);
    assign s_ready   = (state_reg == ST_LOAD_W) || (state_reg == ST_STREAM);
    assign busy      = (state_reg != ST_IDLE);

    always_comb begin
        state_next = state_reg;
        idx_next   = idx_reg;
        cnt_next   = cnt_reg;
        fcnt_next  = fcnt_reg;
        simd_next  = simd_reg;
        bias_next  = bias_reg;
        isw_next   = 8'h00;
        data_next  = '0;
        sum_next   = '0;
        valid_next = 1'b0;
        done_next  = 1'b0;

        case (state_reg)
            ST_IDLE: begin
                if (cmd_valid) begin
                    simd_next = cmd_simd;
`ifdef VMX_FEED_BIAS_EN
                    bias_next = bias_in;
`endif
                    if (cmd_op) begin
                        state_next = ST_STREAM;
                        cnt_next   = cmd_len;
                    end else begin
                        state_next = ST_LOAD_W;
                        idx_next   = LAST_PE;
                    end
                end
            end
            ST_LOAD_W: begin
                // Farthest PE first: the index tag tells PE k to capture this word.
                if (s_valid) begin
                    isw_next  = {1'b1, idx_reg};
                    data_next = s_data;
                    if (idx_reg == 7'd0) begin
                        state_next = ST_IDLE;
                        done_next  = 1'b1;
                    end else begin
                        idx_next = idx_reg - 7'd1;
                    end
                end
            end
            ST_STREAM: begin
                if (s_valid) begin
                    data_next  = s_data;
                    valid_next = 1'b1;
                    sum_next   = bias_reg;
                    if (cnt_reg == 8'd0) begin
                        state_next = ST_FLUSH;
                        fcnt_next  = LAST_PE;
                        done_next  = (LAST_PE == 7'd0);
                    end else begin
                        cnt_next = cnt_reg - 8'd1;
                    end
                end
            end
            ST_FLUSH: begin
                // done is registered, so raise it one cycle ahead of fcnt reaching 0.
                if (fcnt_reg == 7'd0) begin
                    state_next = ST_IDLE;
                end else begin
                    fcnt_next = fcnt_reg - 7'd1;
                    done_next = (fcnt_reg == 7'd1);
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= ST_IDLE;
            idx_reg       <= '0;
            cnt_reg       <= '0;
            fcnt_reg      <= '0;
            simd_reg      <= 1'b0;
            bias_reg      <= '0;
            simd_mode_reg <= 1'b0;
            isw_reg       <= 8'h00;
            data_reg      <= '0;
            sum_reg       <= '0;
            valid_reg     <= 1'b0;
            done_reg      <= 1'b0;
        end else begin
            state_reg     <= state_next;
            idx_reg       <= idx_next;
            cnt_reg       <= cnt_next;
            fcnt_reg      <= fcnt_next;
            simd_reg      <= simd_next;
            bias_reg      <= bias_next;
            simd_mode_reg <= simd_reg;
            isw_reg       <= isw_next;
            data_reg      <= data_next;
            sum_reg       <= sum_next;
            valid_reg     <= valid_next;
            done_reg      <= done_next;
        end
    end

    assign pe_simd_mode = simd_mode_reg;
    assign pe_is_weight = isw_reg;
    assign pe_data      = data_reg;
    assign pe_sum_in    = sum_reg;
    assign pe_valid     = valid_reg;
    assign done         = done_reg;

endmodule

// File: tb/tb_vmx_pe_feeder.sv
// Testbench for vmx_pe_feeder: directed scenarios with literal expectations, then randomized traffic
// checked every cycle against a command-level model of the feeder.
module tb_vmx_pe_feeder;
    localparam int VB     = 16;
    localparam int PB     = 32;
    localparam int NUM_PE = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cmd_valid = 1'b0, cmd_op = 1'b0, cmd_simd = 1'b0;
    logic [7:0]    cmd_len = 8'd0;
    logic [PB-1:0] bias_in = '0;
    logic          s_valid = 1'b0;
    logic [VB-1:0] s_data = '0;
    logic          cmd_ready, s_ready, pe_simd_mode, pe_valid, busy, done;
    logic [7:0]    pe_is_weight;
    logic [VB-1:0] pe_data;
    logic [PB-1:0] pe_sum_in;

    always #5 clk = ~clk;

    vmx_pe_feeder #(.VECTOR_BITLEN(VB), .PRODUCT_BITLEN(PB), .NUM_PE(NUM_PE)) dut (
        .clk(clk), .rst(rst),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_simd(cmd_simd), .cmd_len(cmd_len),
`ifdef VMX_FEED_BIAS_EN
        .bias_in(bias_in),
`endif
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
        .pe_simd_mode(pe_simd_mode), .pe_is_weight(pe_is_weight), .pe_data(pe_data),
        .pe_sum_in(pe_sum_in), .pe_valid(pe_valid), .busy(busy), .done(done)
    );

    // ---------------- command-level reference model ----------------
    localparam int PH_IDLE = 0, PH_WORDS = 1, PH_FLUSH = 2;
    int            m_phase = PH_IDLE;
    int            m_left, m_taken, m_fleft;
    logic          m_op, m_simd, m_known = 1'b0;
    logic [PB-1:0] m_bias;
    logic [7:0]    e_isw;
    logic [VB-1:0] e_data;
    logic [PB-1:0] e_sum;
    logic          e_valid, e_done, e_simd;

    always @(posedge clk) begin
        if (rst) begin
            m_known <= 1'b1; m_phase <= PH_IDLE; m_simd <= 1'b0; m_bias <= '0;
            m_left <= 0; m_taken <= 0; m_fleft <= 0; m_op <= 1'b0;
            e_isw <= 8'h00; e_data <= '0; e_sum <= '0; e_valid <= 1'b0; e_done <= 1'b0; e_simd <= 1'b0;
        end else begin
            e_simd <= m_simd;
            e_isw <= 8'h00; e_data <= '0; e_sum <= '0; e_valid <= 1'b0; e_done <= 1'b0;
            case (m_phase)
                PH_IDLE: if (cmd_valid) begin
                    m_phase <= PH_WORDS; m_op <= cmd_op; m_simd <= cmd_simd; m_taken <= 0;
                    m_left  <= cmd_op ? int'(cmd_len) + 1 : NUM_PE;
`ifdef VMX_FEED_BIAS_EN
                    m_bias  <= bias_in;
`else
                    m_bias  <= '0;
`endif
                end
                PH_WORDS: if (s_valid) begin
                    e_data <= s_data;
                    if (!m_op) e_isw <= 8'h80 | 8'(NUM_PE - 1 - m_taken);
                    else begin e_valid <= 1'b1; e_sum <= m_bias; end
                    m_taken <= m_taken + 1;
                    m_left  <= m_left - 1;
                    if (m_left == 1) begin
                        if (!m_op) begin m_phase <= PH_IDLE; e_done <= 1'b1; end
                        else begin m_phase <= PH_FLUSH; m_fleft <= NUM_PE; e_done <= (NUM_PE == 1); end
                    end
                end
                default: begin
                    // m_fleft counts flush cycles still to come, including the one starting now
                    m_fleft <= m_fleft - 1;
                    if (m_fleft == 1) m_phase <= PH_IDLE;
                    e_done <= (m_fleft == 2);
                end
            endcase
        end
    end

    // ---------------- literal pins set by the directed stimulus ----------------
    logic          pin_en = 1'b0;
    logic [VB-1:0] pin_data;
    logic [7:0]    pin_isw;
    logic          pin_valid, pin_done, pin_busy, pin_simd;
    logic [PB-1:0] pin_sum;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (m_known) begin
            chk("pe_data",      64'(pe_data),      64'(e_data));
            chk("pe_is_weight", 64'(pe_is_weight), 64'(e_isw));
            chk("pe_valid",     64'(pe_valid),     64'(e_valid));
            chk("pe_sum_in",    64'(pe_sum_in),    64'(e_sum));
            chk("pe_simd_mode", 64'(pe_simd_mode), 64'(e_simd));
            chk("done",         64'(done),         64'(e_done));
            chk("busy",         64'(busy),         64'(m_phase != PH_IDLE));
            chk("cmd_ready",    64'(cmd_ready),    64'(m_phase == PH_IDLE));
            chk("s_ready",      64'(s_ready),      64'(m_phase == PH_WORDS));
        end
        if (pin_en) begin
            chk("pin_data",      64'(pe_data),      64'(pin_data));
            chk("pin_is_weight", 64'(pe_is_weight), 64'(pin_isw));
            chk("pin_valid",     64'(pe_valid),     64'(pin_valid));
            chk("pin_done",      64'(done),         64'(pin_done));
            chk("pin_busy",      64'(busy),         64'(pin_busy));
            chk("pin_cmd_ready", 64'(cmd_ready),    64'(!pin_busy));
            chk("pin_simd",      64'(pe_simd_mode), 64'(pin_simd));
            chk("pin_sum",       64'(pe_sum_in),    64'(pin_sum));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
        pin_en = 1'b0;
    endtask

    task automatic pin(input logic [VB-1:0] d, input logic [7:0] w, input logic v, input logic dn,
                       input logic b, input logic sm, input logic [PB-1:0] su);
        pin_data = d; pin_isw = w; pin_valid = v; pin_done = dn;
        pin_busy = b; pin_simd = sm; pin_sum = su; pin_en = 1'b1;
    endtask

    task automatic command(input logic op, input logic simd, input logic [7:0] len);
        cmd_valid = 1'b1; cmd_op = op; cmd_simd = simd; cmd_len = len;
        cyc();
        cmd_valid = 1'b0;
    endtask

    logic [5:0] pat;
    int         w;

    initial begin
        // reset state
        cyc(); cyc();
        pin('0, 8'h00, 0, 0, 0, 0, '0);
        rst = 1'b0;
        cyc();

        // weight load 1..8 back-to-back: tags 0x87 down to 0x80, done with 0x80
        command(1'b0, 1'b0, 8'd0);
        for (int n = 0; n < 8; n++) begin
            s_valid = 1'b1; s_data = VB'(n + 1);
            cyc();
            pin(VB'(n + 1), 8'h87 - 8'(n), 0, (n == 7), (n != 7), 0, '0);
        end
        s_valid = 1'b0;
        cyc();

        // vector, 4 words with a gapped source; bubbles read as zero
        command(1'b1, 1'b0, 8'd3);
        pat = 6'b101101;
        w = 0;
        for (int i = 0; i < 6; i++) begin
            s_valid = pat[5 - i];
            s_data  = pat[5 - i] ? VB'(2 + w) : 16'hdead;
            cyc();
            pin(pat[5 - i] ? VB'(2 + w) : '0, 8'h00, pat[5 - i], 0, 1, 0, '0);
            if (pat[5 - i]) w++;
        end
        s_valid = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            cyc();
            pin('0, 8'h00, 0, (j == 7), 1, 0, '0);
        end
        cyc();
        pin('0, 8'h00, 0, 0, 0, 0, '0);

        // simd vector word
        command(1'b1, 1'b1, 8'd0);
        s_valid = 1'b1; s_data = 16'h0302;
        cyc();
        pin(16'h0302, 8'h00, 1, 0, 1, 1, '0);
        s_valid = 1'b0;
        repeat (8) cyc();

        // command held during a load is taken only once the feeder is idle
        command(1'b0, 1'b0, 8'd0);
        cmd_valid = 1'b1; cmd_op = 1'b1; cmd_len = 8'd0;
        for (int n = 0; n < 8; n++) begin
            s_valid = 1'b1; s_data = VB'(16'h100 + n);
            cyc();
        end
        pin(16'h107, 8'h80, 0, 1, 0, 0, '0);
        s_valid = 1'b0;
        cyc();
        pin('0, 8'h00, 0, 0, 1, 0, '0);
        cmd_valid = 1'b0;
        s_valid = 1'b1; s_data = 16'h55;
        cyc();
        s_valid = 1'b0;
        repeat (9) cyc();

        // reset for two cycles in the middle of a stream
        command(1'b1, 1'b0, 8'd5);
        s_valid = 1'b1; s_data = 16'h11;
        cyc(); cyc();
        rst = 1'b1;
        cyc(); cyc();
        pin('0, 8'h00, 0, 0, 0, 0, '0);
        rst = 1'b0; s_valid = 1'b0;
        cyc();

`ifdef VMX_FEED_BIAS_EN
        // bias is captured at command accept and applied to vector words only
        bias_in = 32'h10;
        command(1'b1, 1'b0, 8'd1);
        bias_in = 32'h55;
        s_valid = 1'b1; s_data = 16'h7;
        cyc();
        pin(16'h7, 8'h00, 1, 0, 1, 0, 32'h10);
        s_data = 16'h8;
        cyc();
        pin(16'h8, 8'h00, 1, 0, 1, 0, 32'h10);
        s_valid = 1'b0;
        for (int j = 1; j <= 7; j++) begin
            cyc();
            pin('0, 8'h00, 0, (j == 7), 1, 0, '0);
        end
        cyc();
`endif

        // randomized traffic against the model
        for (int c = 0; c < 4000; c++) begin
            rst       = ($urandom_range(0, 599) == 0);
            cmd_valid = ($urandom_range(0, 3) == 0);
            cmd_op    = 1'($urandom_range(0, 1));
            cmd_simd  = 1'($urandom_range(0, 1));
            cmd_len   = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 40)) : 8'($urandom_range(0, 5));
            bias_in   = PB'($urandom);
            s_valid   = ($urandom_range(0, 3) != 0);
            s_data    = VB'($urandom);
            cyc();
        end
        rst = 1'b0; cmd_valid = 1'b0; s_valid = 1'b0;
        cyc(); cyc();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
